// File: rtl/data_mem_responder_pkg.sv
// Shared types and RISC-V load/store width codes for the data memory responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/merge, load extract/extend,
// and legality/alignment checking of one request.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  byte_off,
    input  logic        is_read,
    input  logic        is_write,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] word_shift;
    logic [31:0] store_shift;

    always_comb begin
        byte_en     = '0;
        load_data   = '0;
        err         = 1'b0;
        word_shift  = mem_word >> {byte_off, 3'b000};
        store_shift = store_data << {byte_off, 3'b000};

        if (is_read == is_write) begin
            err = 1'b1;
        end else if (is_write) begin
            case (func3)
                F3_SB: byte_en = 4'b0001 << byte_off;
                F3_SH: begin
                    if (byte_off[0]) err = 1'b1;
                    else byte_en = 4'b0011 << {byte_off[1], 1'b0};
                end
                F3_SW: begin
                    if (byte_off != 2'b00) err = 1'b1;
                    else byte_en = 4'b1111;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB:  load_data = {{24{word_shift[7]}}, word_shift[7:0]};
                F3_LBU: load_data = {24'h0, word_shift[7:0]};
                F3_LH: begin
                    if (byte_off[0]) err = 1'b1;
                    else load_data = {{16{word_shift[15]}}, word_shift[15:0]};
                end
                F3_LHU: begin
                    if (byte_off[0]) err = 1'b1;
                    else load_data = {16'h0, word_shift[15:0]};
                end
                F3_LW: begin
                    if (byte_off != 2'b00) err = 1'b1;
                    else load_data = mem_word;
                end
                default: err = 1'b1;
            endcase
        end

        // Lanes without an enable keep the current memory contents.
        merged_word = mem_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) merged_word[b*8 +: 8] = store_shift[b*8 +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with configurable wait states, byte-lane
// stores, sign/zero-extended loads and rejection of illegal accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  resp_valid,
    output logic                  access_err,
    output logic                  mem_busy
);

    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    logic [31:0] mem [WORDS];

    state_t                state;
    logic [2:0]            wait_cnt;
    logic                  lat_read;
    logic                  lat_write;
    logic [DM_ADDRESS-1:0] lat_addr;
    logic [DATA_W-1:0]     lat_data;
    logic [2:0]            lat_func3;

    logic                  cur_read;
    logic                  cur_write;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DATA_W-1:0]     cur_data;
    logic [2:0]            cur_func3;

    logic [3:0]            byte_en;
    logic [31:0]           merged_word;
    logic [31:0]           load_data;
    logic                  align_err;

    // While idle the aligner looks at the live request so a zero-wait load
    // has its result ready on the edge that moves into RESP.
    assign cur_read  = (state == IDLE) ? MemRead  : lat_read;
    assign cur_write = (state == IDLE) ? MemWrite : lat_write;
    assign cur_addr  = (state == IDLE) ? addr     : lat_addr;
    assign cur_data  = (state == IDLE) ? wr_data  : lat_data;
    assign cur_func3 = (state == IDLE) ? func3    : lat_func3;

    dmem_lane_align u_align (
        .func3      (cur_func3),
        .byte_off   (cur_addr[1:0]),
        .is_read    (cur_read),
        .is_write   (cur_write),
        .store_data (cur_data),
        .mem_word   (mem[cur_addr[DM_ADDRESS-1:2]]),
        .byte_en    (byte_en),
        .merged_word(merged_word),
        .load_data  (load_data),
        .err        (align_err)
    );

    assign req_ready  = (state == IDLE);
    assign mem_busy   = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign access_err = (state == RESP) && align_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_func3 <= '0;
            rd_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_read  <= MemRead;
                        lat_write <= MemWrite;
                        lat_addr  <= addr;
                        lat_data  <= wr_data;
                        lat_func3 <= func3;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 3'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                            if (MemRead && !align_err) rd_data <= load_data;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= RESP;
                        if (lat_read && !align_err) rd_data <= load_data;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset; a store commits only on the edge that leaves RESP.
    always_ff @(posedge clk) begin
        if (reset && state == RESP && lat_write && !align_err) begin
            mem[lat_addr[DM_ADDRESS-1:2]] <= merged_word;
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width (512-byte space, 128 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..7, added response wait states.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port MemRead  input  1  load request.
REQ-009 SHALL have port MemWrite  input  1  store request.
REQ-010 SHALL have port addr  input  DM_ADDRESS  byte address.
REQ-011 SHALL have port wr_data  input  DATA_W  store data, right-aligned.
REQ-012 SHALL have port func3  input  3  RISC-V load/store width code.
REQ-013 SHALL have port rd_data  output  DATA_W  extended load result.
REQ-014 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-015 SHALL have port access_err  output  1  qualifies resp_valid; request rejected.
REQ-016 SHALL have port mem_busy  output  1  pipeline stall request.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 In IDLE: req_ready=1; req_valid high at an edge latches MemRead, MemWrite, addr, wr_data, func3; next state WAIT if WAIT_CYCLES>0, else RESP.
REQ-019 In WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; transition to RESP when counter is 0.
REQ-020 In RESP: resp_valid=1 for exactly one cycle, store committed at end of this cycle, then IDLE; req_ready=0 in WAIT and RESP.
REQ-021 Latency: request accepted at edge N gives resp_valid high in cycle N+1+WAIT_CYCLES; throughput one request per 2+WAIT_CYCLES cycles.
REQ-022 mem_busy SHALL be high whenever state is not IDLE.
REQ-023 Storage: 128 x 32-bit words, little-endian, word index addr[8:2]; byte-lane writes.
REQ-024 Stores: func3 000 SB (lane addr[1:0]), 001 SH (lanes addr[1]*2, +1), 010 SW; unwritten lanes unchanged.
REQ-025 Loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-026 access_err SHALL be set with resp_valid, with no storage change and rd_data held, for: halfword with addr[0]=1; word with addr[1:0]!=0; undefined func3; MemRead and MemWrite both high; both low.
REQ-027 rd_data SHALL update only on a successful load response and hold its value otherwise.
REQ-028 Store response: resp_valid=1, access_err=0, rd_data unchanged.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE, counter 0, resp_valid 0, access_err 0, mem_busy 0, rd_data 0; req_ready 1 after release.
REQ-030 Reset mid-operation SHALL abort the pending request; an uncommitted store SHALL NOT modify storage.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 Shared package SHALL hold the FSM state enum typedef and the func3 width-code constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-033 One combinational sub-module, dmem_lane_align, SHALL perform store byte-enable/merge generation, load extraction/extension and the misalignment check.

Verification
REQ-034 WAIT_CYCLES=1: SW 0xDEADBEEF to 0x010, accepted at edge N -> resp_valid in cycle N+2, mem_busy high in cycles N+1..N+2; LW 0x010 -> rd_data 0xDEADBEEF.
REQ-035 After REQ-034 data: SB 0x7F to 0x011; LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LW 0x010 -> 0xDEAD7FEF.
REQ-036 LH 0x012 -> 0xFFFFDEAD; LHU 0x012 -> 0x0000DEAD; LH 0x011 -> access_err=1, rd_data unchanged; SW 0x022 -> access_err=1, word 0x020 unchanged.
REQ-037 WAIT_CYCLES=0, back-to-back req_valid held high -> responses every 2 cycles, req_ready low in RESP, no request lost or duplicated.
REQ-038 SW 0x12345678 to 0x040 with reset asserted during WAIT -> all outputs at reset values immediately; subsequent LW 0x040 returns the prior contents, not 0x12345678.
REQ-039 MemRead=MemWrite=1, or func3=011 -> access_err=1 with resp_valid, storage unchanged.
